alu_seq: RTL
============

# alu_seq

Microcode-side driver for the 8-bit ALU. It accepts one arithmetic or logic request and its operands. It then plays the three-cycle ALU control-line sequence: load A, load B with low-nibble compute, then high-nibble compute with result output enable. It captures the ALU's result, zero and carry, and returns a single-cycle response with Game Boy style flags. It sits between the instruction decoder and the ALU and is the only writer of the ALU control lines.

## Interface

Parameters:
- none (datapath fixed at 8 bits, nibble-split ALU)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_op  in  3  0 AND, 1 OR, 2 XOR, 3 ADD, 4 ADC, 5 SUB, 6 SBC, 7 CP
- req_a  in  8  operand A
- req_b  in  8  operand B
- req_cin  in  1  incoming carry flag, used by ADC/SBC
- alu_op  out  8  ALU operand bus
- alu_la / alu_lb  out  1 each  load A / load B latch strobes
- alu_sh  out  2  shifter select, held 0 (no shift)
- alu_oe  out  1  0 = shifter onto bus, 1 = result onto bus
- alu_r, alu_s, alu_v, alu_ne, alu_ci  out  1 each  function select, B-invert, carry-in
- alu_l / alu_h  out  1 each  compute low / high nibble
- alu_result  in  8  ALU result bus
- alu_zero, alu_carry  in  1 each  ALU flags
- rsp_valid  out  1  one-cycle response strobe
- rsp_result  out  8  result (A for CP)
- rsp_z, rsp_n, rsp_h, rsp_c  out  1 each  flags

## Operation

- States: IDLE → LDA → LO → HI → IDLE. No other states. Illegal encodings go to IDLE.
- IDLE: all alu_* strobes 0; alu_oe=0; alu_op=0; function lines 0. On accept, latch op, a, b and cin, then go to LDA.
- LDA: alu_op=a, alu_la=1, alu_oe=0.
- LO: alu_op=b, alu_lb=1, alu_l=1, function lines per op, alu_oe=0. Register alu_carry as the half-carry.
- HI: alu_h=1, alu_oe=1, function lines per op, la=lb=0. Register alu_result, alu_zero and alu_carry.
- Function encoding (r,s,v):
  - AND (0,1,1)
  - OR (1,1,1)
  - XOR (1,0,1)
  - ADD/ADC/SUB/SBC/CP (1,0,0)
- ne=1 only for SUB/SBC/CP.
- Carry-in (ci):
  - logic ops 0
  - ADD 0
  - ADC cin
  - SUB/CP 1
  - SBC !cin
- Flags:
  - z = alu_zero for all ops.
  - n = 1 for SUB/SBC/CP, else 0.
  - c: logic ops 0; ADD/ADC alu_carry; SUB/SBC/CP !alu_carry (borrow).
  - h: AND 1; OR/XOR 0; ADD/ADC low-nibble carry; SUB/SBC/CP inverted low-nibble carry.
- rsp_result = captured alu_result, except CP, which returns the latched a.

## Timing

- Accept at edge E0. LDA during cycle 1, LO cycle 2, HI cycle 3. rsp_valid high during cycle 4 only.
- Latency is 4 cycles from the accept edge.
- req_ready=1 again in cycle 4, so a back-to-back request is accepted at the end of cycle 4. Throughput is one op per 4 cycles.
- Requests are ignored while req_ready=0. Operands are latched, so the input may change after acceptance.
- rsp_result and flags hold their last value until the next capture. Only rsp_valid pulses.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, all flags 0, all alu_* outputs 0.
- Reset in any state aborts the op. No rsp_valid is issued for the aborted op. The next cycle shows IDLE outputs.

## Test plan

- OR a=0x5A b=0x0F: LDA shows alu_op=0x5A la=1; LO shows alu_op=0x0F lb=1 l=1 r=s=v=1; HI shows oe=1 h=1 → rsp 0x5F, z=0 n=0 h=0 c=0 at cycle 4.
- ADD 0xFF+0x01 → 0x00, z=1 h=1 c=1 n=0. ADC 0x0E+0x01 with cin=1 → 0x10, h=1 c=0.
- SUB 0x10−0x01 (ne=1 ci=1) → 0x0F, n=1 h=1 c=0. SBC 0x00−0x00 with cin=1 → 0xFF, c=1 h=1.
- CP 0x3C vs 0x3C → rsp_result=0x3C, z=1 n=1 c=0. AND 0xF0&0x0F → 0x00, z=1 h=1.
- Back-to-back: req_valid held high with two ops. The second accept occurs exactly in the rsp_valid cycle of the first, and responses are 4 cycles apart. A request offered during LDA/LO/HI is not accepted.
- Reset asserted during LO: no rsp_valid. Outputs equal reset values the next cycle, and a fresh OR request completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// Microcode-side sequencer for the nibble-split 8-bit ALU: plays load A, load B + low
// nibble, high nibble + output enable, then returns one response with GB-style flags.
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cin,
    output logic [7:0] alu_op,
    output logic       alu_la,
    output logic       alu_lb,
    output logic [1:0] alu_sh,
    output logic       alu_oe,
    output logic       alu_r,
    output logic       alu_s,
    output logic       alu_v,
    output logic       alu_ne,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       rsp_valid,
    output logic [7:0] rsp_result,
    output logic       rsp_z,
    output logic       rsp_n,
    output logic       rsp_h,
    output logic       rsp_c
);
    // state | meaning
    // IDLE  | ready for a request; all ALU lines low
    // LDA   | operand A on bus, load A strobe
    // LO    | operand B on bus, load B, low-nibble compute
    // HI    | high-nibble compute, result driven onto bus
    typedef enum logic [1:0] {IDLE, LDA, LO, HI} state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_ADC = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SBC = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    state_t     state;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       cin_q;
    logic       hc_q;
    logic       is_sub;
    logic       is_logic;

    // {r, s, v, ne, ci}
    function automatic logic [4:0] fn_lines(input logic [2:0] op, input logic cin);
        case (op)
            OP_AND:  fn_lines = 5'b011_0_0;
            OP_OR:   fn_lines = 5'b111_0_0;
            OP_XOR:  fn_lines = 5'b101_0_0;
            OP_ADD:  fn_lines = 5'b100_0_0;
            OP_ADC:  fn_lines = {4'b100_0, cin};
            OP_SUB:  fn_lines = 5'b100_1_1;
            OP_SBC:  fn_lines = {4'b100_1, ~cin};
            default: fn_lines = 5'b100_1_1;
        endcase
    endfunction

    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    assign is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
    assign alu_sh   = 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            op_q       <= 3'd0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            cin_q      <= 1'b0;
            hc_q       <= 1'b0;
            alu_op     <= 8'h00;
            alu_la     <= 1'b0;
            alu_lb     <= 1'b0;
            alu_oe     <= 1'b0;
            {alu_r, alu_s, alu_v, alu_ne, alu_ci} <= 5'b0;
            alu_l      <= 1'b0;
            alu_h      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'h00;
            {rsp_z, rsp_n, rsp_h, rsp_c} <= 4'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        cin_q     <= req_cin;
                        req_ready <= 1'b0;
                        alu_op    <= req_a;
                        alu_la    <= 1'b1;
                        state     <= LDA;
                    end
                end
                LDA: begin
                    alu_la <= 1'b0;
                    alu_op <= b_q;
                    alu_lb <= 1'b1;
                    alu_l  <= 1'b1;
                    {alu_r, alu_s, alu_v, alu_ne, alu_ci} <= fn_lines(op_q, cin_q);
                    state  <= LO;
                end
                LO: begin
                    hc_q   <= alu_carry;
                    alu_op <= 8'h00;
                    alu_lb <= 1'b0;
                    alu_l  <= 1'b0;
                    alu_h  <= 1'b1;
                    alu_oe <= 1'b1;
                    state  <= HI;
                end
                HI: begin
                    rsp_result <= (op_q == OP_CP) ? a_q : alu_result;
                    rsp_z      <= alu_zero;
                    rsp_n      <= is_sub;
                    rsp_c      <= is_logic ? 1'b0 : (is_sub ? ~alu_carry : alu_carry);
                    rsp_h      <= (op_q == OP_AND) ? 1'b1 :
                                  is_logic ? 1'b0 : (is_sub ? ~hc_q : hc_q);
                    rsp_valid  <= 1'b1;
                    req_ready  <= 1'b1;
                    alu_h      <= 1'b0;
                    alu_oe     <= 1'b0;
                    {alu_r, alu_s, alu_v, alu_ne, alu_ci} <= 5'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    alu_op    <= 8'h00;
                    alu_la    <= 1'b0;
                    alu_lb    <= 1'b0;
                    alu_oe    <= 1'b0;
                    {alu_r, alu_s, alu_v, alu_ne, alu_ci} <= 5'b0;
                    alu_l     <= 1'b0;
                    alu_h     <= 1'b0;
                end
            endcase
        end
    end
endmodule
